// File: rtl/i2s_codec_bridge.sv
// I2S master bridge between the audio codec and packet_manager.
// Generates BCLK/LRCLK from clk, captures the codec ADC left channel as
// 16-bit samples, and plays accepted DAC samples on both channels.
// Frame = 32 BCLK: slots 1..16 carry the left word, 17..31 and 0 the right
// word (slot 0 also carries the one-BCLK-delayed LSB of the previous word).
module i2s_codec_bridge #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_dac_sd,
  input  logic        i2s_adc_sd,
  output logic [15:0] adc_data_out,
  output logic        adc_data_valid,
  input  logic [15:0] dac_data_in,
  input  logic        dac_data_valid,
  output logic        dac_ready,
  output logic        dac_underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] SLOT_FIRST     = 5'd1;
  localparam logic [4:0] SLOT_LEFT_LAST = 5'd16;

  // Bit position of the word carried in a slot: (16 - s) mod 16.
  // Slot 1 -> bit 15 ... slot 16 -> bit 0, slot 17 -> bit 15 ... slot 0 -> bit 0.
  function automatic logic [3:0] tx_bit_index(input logic [3:0] s_low);
    return 4'd0 - s_low;
  endfunction

  // Registered state
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  // Only the 15 most recent ADC bits are ever needed: the 16th comes
  // straight from the pin in the capture cycle.
  logic [14:0]      rx_shift;
  logic [15:0]      tx_cur;
  logic [15:0]      hold_data;
  logic             hold_full;

  // Decoded controls
  logic        half_tick;
  logic        rise_ev;
  logic        fall_ev;
  logic [4:0]  slot_next;
  logic        frame_start;
  logic        tx_load;
  logic        accept;
  logic        left_rise;
  logic [15:0] tx_word;
  logic        tx_bit;
  logic [15:0] rx_next;

  // Holding register is the only buffer, so ready simply reflects it.
  assign dac_ready = ~hold_full;

  // Decode divider wrap into BCLK edges and derive the per-edge frame controls.
  always_comb begin
    half_tick   = 1'b0;
    rise_ev     = 1'b0;
    fall_ev     = 1'b0;
    slot_next   = slot + 5'd1;
    frame_start = 1'b0;
    tx_load     = 1'b0;
    accept      = 1'b0;
    left_rise   = 1'b0;
    tx_word     = tx_cur;
    tx_bit      = 1'b0;
    rx_next     = {rx_shift, i2s_adc_sd};

    if (div_cnt == DIV_LAST) begin
      half_tick = 1'b1;
    end else begin
      half_tick = 1'b0;
    end

    rise_ev = half_tick & ~i2s_bclk;
    fall_ev = half_tick & i2s_bclk;

    if (fall_ev && (slot_next == SLOT_FIRST)) begin
      frame_start = 1'b1;
    end else begin
      frame_start = 1'b0;
    end

    tx_load = frame_start & hold_full;
    // An offer in the load cycle only sees an empty hold; the load itself
    // is decided on the old hold state, so the new sample waits a frame.
    accept  = dac_data_valid & ~hold_full;

    // The word loaded at frame start must already drive the first bit.
    if (tx_load) begin
      tx_word = hold_data;
    end else begin
      tx_word = tx_cur;
    end
    tx_bit = tx_word[tx_bit_index(slot_next[3:0])];

    if (rise_ev && (slot >= SLOT_FIRST) && (slot <= SLOT_LEFT_LAST)) begin
      left_rise = 1'b1;
    end else begin
      left_rise = 1'b0;
    end
  end

  // Clock divider: BCLK toggles once every CLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (half_tick) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Slot counter, word select and DAC serial bit all advance on the BCLK fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot       <= 5'd0;
      i2s_lrclk  <= 1'b0;
      i2s_dac_sd <= 1'b0;
    end else if (fall_ev) begin
      slot       <= slot_next;
      i2s_lrclk  <= slot_next[4];
      i2s_dac_sd <= tx_bit;
    end else begin
      slot       <= slot;
      i2s_lrclk  <= i2s_lrclk;
      i2s_dac_sd <= i2s_dac_sd;
    end
  end

  // DAC holding register, frame-start word load and starvation pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_data    <= 16'h0000;
      tx_cur       <= 16'h0000;
      dac_underrun <= 1'b0;
    end else begin
      dac_underrun <= frame_start & ~hold_full;
      if (tx_load) begin
        tx_cur    <= hold_data;
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_data <= dac_data_in;
        hold_full <= 1'b1;
      end else begin
        hold_full <= hold_full;
      end
    end
  end

  // ADC left-slot deserialiser: MSB first, capture and pulse on the slot-16 rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift       <= 15'h0000;
      adc_data_out   <= 16'h0000;
      adc_data_valid <= 1'b0;
    end else begin
      adc_data_valid <= 1'b0;
      if (left_rise) begin
        rx_shift <= rx_next[14:0];
        if (slot == SLOT_LEFT_LAST) begin
          adc_data_out   <= rx_next;
          adc_data_valid <= 1'b1;
        end else begin
          adc_data_out   <= adc_data_out;
        end
      end else begin
        rx_shift <= rx_shift;
      end
    end
  end

endmodule
